alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
Bit-serial ALU sequencer. It accepts one operand pair and opcode per request and drives a single 1-bit ALU slice for WIDTH cycles, LSB first. It feeds the carry chain back through a register, resolves SLT after the MSB is known, and returns result, zero and overflow through a valid/ready handshake. It is the area-reduced alternative to the 32-slice ripple ALU and uses the same opcode encoding.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (IDLE only)
a  input  WIDTH  operand A, sampled on request handshake
b  input  WIDTH  operand B, sampled on request handshake
alu_control  input  4  opcode, sampled on request handshake
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
result  output  WIDTH  operation result
zero  output  1  result == 0
overflow  output  1  signed overflow (ADD/SUB only)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset). Reset forces state IDLE and clears the operand/result/count/carry registers. Output reset values: req_ready=1, rsp_valid=0, result=0, zero=0, overflow=0.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (b inverted, initial carry 1).
  - 0111 SLT (subtract; result = {0.., set}).
  - 1100 NOR.
  - Any other opcode: result 0, zero 1, overflow 0. The request still completes with normal latency.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch a, b and opcode. Set carry = 1 for 0110/0111, else 0. Set bit index = 0. Go to RUN.
  - RUN: each cycle, evaluate the slice on a[i], b[i] and the carry register. Shift the slice result into the result register at bit i and update carry. The slice's less input is tied 0 (0 for bits 0..WIDTH-2 per the slice contract; SLT bit 0 is inserted in FIX, so less is never used for the MSB). At i == WIDTH-1, capture set = MSB sum and overflow = carry_in XOR carry_out of the MSB, then go to FIX.
  - FIX: for SLT, result = set in bit 0 with zeros elsewhere. Compute zero. Mask overflow to 0 unless the opcode is 0010 or 0110. Go to DONE.
  - DONE: rsp_valid=1; result, zero and overflow are held stable. On rsp_ready, go to IDLE. req_ready is 0 throughout RUN, FIX and DONE.
- Latency: fixed at WIDTH+2 cycles from the request handshake to rsp_valid (WIDTH RUN cycles, 1 FIX cycle, entry into DONE). With WIDTH=32, rsp_valid rises 34 cycles after accept.
- Throughput: a new request is accepted no earlier than the cycle after the response handshake. There is no overlap.
- Input stability: requests presented while req_ready=0 are ignored. a, b and alu_control may change after the handshake without effect.
- Simultaneous events: a response handshake in DONE and req_valid in the same cycle: the request is not accepted that cycle (req_ready=0). It is accepted the next cycle in IDLE.
- Reset mid-operation: the in-flight request is discarded with no response, and outputs return to reset values immediately (asynchronous).
- Counter: width $clog2(WIDTH). It must not wrap during RUN; the terminal compare is on WIDTH-1.

Optional Feature:
SLT_OVF_CORRECT_EN
- Defined: SLT set bit = MSB sum XOR overflow, giving a correct signed comparison when the subtraction overflows.
- Undefined: set = uncorrected MSB sum, which is bit-exact with the existing combinational ALU.
- ADD, SUB and the logical opcodes are unaffected either way.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100;
  - state enum {IDLE, RUN, FIX, DONE}.
- One sub-module is natural: alu_seq_slice, a 1-bit full-adder/logic slice. Inputs: a, b, alu_control, carry_in, less. Outputs: result, carry_out, set, overflow. It is instantiated once and reused every cycle.

Test Plan (WIDTH=32):
- ADD a=0x7FFFFFFF, b=0x00000001, rsp_ready=1 -> rsp_valid 34 cycles after accept; result 0x80000000, overflow 1, zero 0.
- SUB a=5, b=5 -> result 0x00000000, zero 1, overflow 0.
- SLT a=0xFFFFFFFF, b=0x00000001 -> result 0x00000001. SLT a=0x80000000, b=1 -> result 0 without SLT_OVF_CORRECT_EN, 1 with it; overflow 0 in both.
- NOR a=0, b=0 -> 0xFFFFFFFF. Opcode 0101 -> result 0, zero 1 after 34 cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> result/flags stable, req_ready=0. A second request held on req_valid is accepted exactly one cycle after the response handshake.
- Assert reset at RUN bit 10 -> rsp_valid never rises for that request; req_ready=1 and result=0 immediately. The next request completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and sequencer state type for the bit-serial ALU.
// Opcodes match the combinational ripple ALU so both are interchangeable.
package alu_seq_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } state_e;

endpackage

// File: rtl/alu_seq_slice.sv
// One-bit ALU slice: full adder with optional B inversion plus logic ops.
// Reused once per cycle by the serial sequencer.
module alu_seq_slice
   import alu_seq_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic [3:0] alu_control,
   input  logic       carry_in,
   input  logic       less,
   output logic       result,
   output logic       carry_out,
   output logic       set,
   output logic       overflow
);

   logic b_eff;
   logic sum;

   always_comb begin
      // alu_control[2] selects B inversion (SUB/SLT)
      b_eff     = b ^ alu_control[2];
      sum       = a ^ b_eff ^ carry_in;
      carry_out = (a & b_eff) | (a & carry_in) | (b_eff & carry_in);
      set       = sum;
      overflow  = carry_in ^ carry_out;
      case (alu_control)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = sum;
         ALU_SUB: result = sum;
         ALU_SLT: result = less;
         ALU_NOR: result = ~(a | b);
         default: result = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: WIDTH slice cycles LSB first, then SLT fix-up.
// Define SLT_OVF_CORRECT_EN to correct the SLT set bit for subtraction overflow.
module alu_serial_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow
);

   localparam int unsigned     CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [3:0]       op_q, op_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d, set_q, set_d;
   logic             ovf_q, ovf_d, zero_q, zero_d;
   logic [WIDTH-1:0] fin;
   logic             s_res, s_cout, s_set, s_ovf;

   alu_seq_slice u_slice (
      .a           (a_q[0]),
      .b           (b_q[0]),
      .alu_control (op_q),
      .carry_in    (carry_q),
      .less        (1'b0),
      .result      (s_res),
      .carry_out   (s_cout),
      .set         (s_set),
      .overflow    (s_ovf)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = RUN;
         RUN:     if (cnt_q == LAST) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == DONE);
   end

   // Operands shift right and results shift in at the MSB, so bit i of each
   // operand reaches the slice at step i and lands at result bit i after WIDTH steps.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      set_d   = set_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      fin     = (op_q == ALU_SLT) ? {{(WIDTH-1){1'b0}}, set_q} : res_q;
      case (state_q)
         IDLE: if (req_valid) begin
            a_d     = a;
            b_d     = b;
            op_d    = alu_control;
            carry_d = (alu_control == ALU_SUB) || (alu_control == ALU_SLT);
            cnt_d   = '0;
            zero_d  = 1'b0;
            ovf_d   = 1'b0;
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = {s_res, res_q[WIDTH-1:1]};
            carry_d = s_cout;
            if (cnt_q == LAST) begin
`ifdef SLT_OVF_CORRECT_EN
               set_d = s_set ^ s_ovf;
`else
               set_d = s_set;
`endif
               ovf_d = s_ovf;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FIX: begin
            res_d  = fin;
            zero_d = (fin == '0);
            ovf_d  = ovf_q & ((op_q == ALU_ADD) || (op_q == ALU_SUB));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         set_q   <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         set_q   <= set_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign result   = res_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq against an arithmetic reference model.
// Honours SLT_OVF_CORRECT_EN when the macro is defined for the whole build.
module tb_alu_serial_seq;

   localparam int unsigned W   = 32;
   localparam int          LAT = W + 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [3:0]    alu_control = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [W-1:0]  result;
   logic          zero;
   logic          overflow;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   alu_serial_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .a           (a),
      .b           (b),
      .alu_control (alu_control),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .result      (result),
      .zero        (zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
      $fatal(1, "watchdog expired");
   end

   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [3:0] op, output logic [W-1:0] r,
                                 output logic z, output logic o);
      logic [W-1:0] d;
      r = '0;
      o = 1'b0;
      case (op)
         4'b0000: r = x & y;
         4'b0001: r = x | y;
         4'b0010: begin
            r = x + y;
            o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
         end
         4'b0110: begin
            r = x - y;
            o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
         end
         4'b0111: begin
            d = x - y;
`ifdef SLT_OVF_CORRECT_EN
            r = ($signed(x) < $signed(y)) ? W'(1) : '0;
`else
            r = d[W-1] ? W'(1) : '0;
`endif
         end
         4'b1100: r = ~(x | y);
         default: r = '0;
      endcase
      z = (r == '0);
   endfunction

   function automatic logic [3:0] pick_op();
      case ($urandom_range(0, 6))
         0: return 4'b0000;
         1: return 4'b0001;
         2: return 4'b0010;
         3: return 4'b0110;
         4: return 4'b0111;
         5: return 4'b1100;
         default: return 4'($urandom);
      endcase
   endfunction

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return {1'b1, {(W-1){1'b0}}};
         3: return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   // Drives one request from a negedge; returns cycles from accept to rsp_valid.
   task automatic transact(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic [3:0] op, output int lat,
                           output logic [W-1:0] r, output logic z, output logic o);
      int guard;
      a = ta;
      b = tb_;
      alu_control = op;
      req_valid = 1'b1;
      guard = 0;
      while (!req_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      alu_control = 4'($urandom);
      lat = 1;
      while (!rsp_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      r = result;
      z = zero;
      o = overflow;
      if (rsp_ready) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", result); end
      n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero: got %b expected 0", zero); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [W-1:0] va [8];
      logic [W-1:0] vb [8];
      logic [3:0]   vop [8];
      logic [W-1:0] r, er;
      logic         z, o, ez, eo;
      int           lat;
      va[0] = 32'h7FFFFFFF; vb[0] = 32'h00000001; vop[0] = 4'b0010;
      va[1] = 32'd5;        vb[1] = 32'd5;        vop[1] = 4'b0110;
      va[2] = 32'hFFFFFFFF; vb[2] = 32'h00000001; vop[2] = 4'b0111;
      va[3] = 32'h80000000; vb[3] = 32'h00000001; vop[3] = 4'b0111;
      va[4] = 32'h00000000; vb[4] = 32'h00000000; vop[4] = 4'b1100;
      va[5] = 32'h12345678; vb[5] = 32'h9ABCDEF0; vop[5] = 4'b0101;
      va[6] = 32'hF0F0A5A5; vb[6] = 32'h3C3C0FF0; vop[6] = 4'b0000;
      va[7] = 32'hF0F0A5A5; vb[7] = 32'h3C3C0FF0; vop[7] = 4'b0001;
      for (int i = 0; i < 8; i++) begin
         model(va[i], vb[i], vop[i], er, ez, eo);
         transact(va[i], vb[i], vop[i], lat, r, z, o);
         n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, LAT); end
         n_cmp++; if (r !== er) begin n_bad++; $display("FAIL dir%0d_result op=%b: got %h expected %h", i, vop[i], r, er); end
         n_cmp++; if (z !== ez) begin n_bad++; $display("FAIL dir%0d_zero: got %b expected %b", i, z, ez); end
         n_cmp++; if (o !== eo) begin n_bad++; $display("FAIL dir%0d_overflow: got %b expected %b", i, o, eo); end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] x, y, r, er;
      logic [3:0]   op;
      logic         z, o, ez, eo;
      int           lat;
      for (int i = 0; i < 60; i++) begin
         x  = pick_operand();
         y  = pick_operand();
         op = pick_op();
         if ($urandom_range(0, 5) == 0) y = x;
         model(x, y, op, er, ez, eo);
         transact(x, y, op, lat, r, z, o);
         n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, LAT); end
         n_cmp++; if (r !== er) begin n_bad++; $display("FAIL rnd%0d_result op=%b a=%h b=%h: got %h expected %h", i, op, x, y, r, er); end
         n_cmp++; if (z !== ez) begin n_bad++; $display("FAIL rnd%0d_zero: got %b expected %b", i, z, ez); end
         n_cmp++; if (o !== eo) begin n_bad++; $display("FAIL rnd%0d_overflow: got %b expected %b", i, o, eo); end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] x1, y1, x2, y2, r, er;
      logic         z, o, ez, eo;
      int           lat;
      x1 = W'($urandom); y1 = W'($urandom);
      x2 = W'($urandom); y2 = W'($urandom);
      rsp_ready = 1'b0;
      model(x1, y1, 4'b0010, er, ez, eo);
      transact(x1, y1, 4'b0010, lat, r, z, o);
      n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL bp_latency: got %0d expected %0d", lat, LAT); end
      n_cmp++; if (r !== er) begin n_bad++; $display("FAIL bp_result: got %h expected %h", r, er); end
      a = x2; b = y2; alu_control = 4'b0110; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold%0d_rsp_valid: got %b expected 1", i, rsp_valid); end
         n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold%0d_req_ready: got %b expected 0", i, req_ready); end
         n_cmp++; if (result !== er) begin n_bad++; $display("FAIL bp_hold%0d_result: got %h expected %h", i, result, er); end
         n_cmp++; if ({zero, overflow} !== {ez, eo}) begin n_bad++; $display("FAIL bp_hold%0d_flags: got %b%b expected %b%b", i, zero, overflow, ez, eo); end
      end
      rsp_ready = 1'b1;
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_handshake_req_ready: got %b expected 0", req_ready); end
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept_req_ready: got %b expected 1", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_accept_rsp_valid: got %b expected 0", rsp_valid); end
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      model(x2, y2, 4'b0110, er, ez, eo);
      n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); end
      n_cmp++; if (result !== er) begin n_bad++; $display("FAIL b2b_result: got %h expected %h", result, er); end
      n_cmp++; if ({zero, overflow} !== {ez, eo}) begin n_bad++; $display("FAIL b2b_flags: got %b%b expected %b%b", zero, overflow, ez, eo); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] r, er;
      logic         z, o, ez, eo;
      logic         seen;
      int           lat;
      a = 32'h0F0F0F0F; b = 32'h01010101; alu_control = 4'b0010; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_req_ready: got %b expected 1", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_rsp_valid: got %b expected 0", rsp_valid); end
      n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL mid_reset_result: got %h expected 0", result); end
      n_cmp++; if ({zero, overflow} !== 2'b00) begin n_bad++; $display("FAIL mid_reset_flags: got %b%b expected 00", zero, overflow); end
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_reset_no_response: got %b expected 0", seen); end
      model(32'hDEADBEEF, 32'h0BADF00D, 4'b0110, er, ez, eo);
      transact(32'hDEADBEEF, 32'h0BADF00D, 4'b0110, lat, r, z, o);
      n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, LAT); end
      n_cmp++; if (r !== er) begin n_bad++; $display("FAIL post_reset_result: got %h expected %h", r, er); end
      n_cmp++; if ({z, o} !== {ez, eo}) begin n_bad++; $display("FAIL post_reset_flags: got %b%b expected %b%b", z, o, ez, eo); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
